// File: rtl/bnn_batch_sequencer_if.sv
// Handshake bundle shared by the sample source, the BNN engine and the result consumer.
// The master modport is the sequencer's view; slave is the surrounding environment.
interface bnn_batch_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_features;
    logic        eng_start;
    logic [15:0] eng_features;
    logic        eng_done;
    logic        eng_class;
    logic        out_valid;
    logic        out_ready;
    logic        out_class;
    logic [3:0]  out_votes;
    logic        out_error;

    modport master (
        input  in_valid, in_features, eng_done, eng_class, out_ready,
        output in_ready, eng_start, eng_features, out_valid, out_class, out_votes, out_error
    );

    modport slave (
        output in_valid, in_features, eng_done, eng_class, out_ready,
        input  in_ready, eng_start, eng_features, out_valid, out_class, out_votes, out_error
    );
endinterface

// File: rtl/bnn_batch_sequencer.sv
// Sample FIFO plus launch/collect FSM for the 4-feature microgreen BNN engine:
// launches one sample at a time, majority-votes BATCH results, and aborts hung samples.
module bnn_batch_sequencer #(
    parameter int DEPTH   = 4,
    parameter int BATCH   = 5,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    bnn_batch_sequencer_if.master bus,
    output logic                 busy
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_L    = (AW+1)'(DEPTH);
    localparam logic [3:0]  BATCH_L   = 4'(BATCH);
    localparam logic [4:0]  BATCH_X   = 5'(BATCH);
    localparam logic [7:0]  TIMEOUT_L = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_ACCUM,
        S_REPORT
    } state_e;

    state_e        state_q;
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic [3:0]    votes_q, cnt_q;
    logic          err_q;
    logic [7:0]    wdog_q, wdog_d;
    logic          eng_start_q;
    logic [15:0]   eng_features_q;
    logic          out_valid_q, out_class_q, out_error_q;
    logic [3:0]    out_votes_q;

    logic          fifo_empty, fifo_full, push, pop, batch_full;
    logic [4:0]    votes_x2;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == FULL_L);
        push       = bus.in_valid & ena & ~fifo_full;
        batch_full = (cnt_q == BATCH_L);
        // A pop is exactly the move into LAUNCH, so the head is consumed once per start pulse.
        pop        = ena & ~fifo_empty &
                     ((state_q == S_IDLE) | ((state_q == S_ACCUM) & ~batch_full));
        count_d    = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        wdog_d     = wdog_q + 8'd1;
        votes_x2   = {votes_q, 1'b0};
    end

    assign bus.in_ready     = ena & ~fifo_full;
    assign bus.eng_start    = eng_start_q & ena;
    assign bus.eng_features = eng_features_q;
    assign bus.out_valid    = out_valid_q;
    assign bus.out_class    = out_class_q;
    assign bus.out_votes    = out_votes_q;
    assign bus.out_error    = out_error_q;
    assign busy             = (state_q != S_IDLE) | ~fifo_empty;

    // NOTE: sample storage has no reset; the pointers and occupancy alone define emptiness.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_features;
        end
    end

    // NOTE: every register here uses <= so all next-state terms see the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            votes_q        <= '0;
            cnt_q          <= '0;
            err_q          <= 1'b0;
            wdog_q         <= '0;
            eng_start_q    <= 1'b0;
            eng_features_q <= '0;
            out_valid_q    <= 1'b0;
            out_class_q    <= 1'b0;
            out_votes_q    <= '0;
            out_error_q    <= 1'b0;
        end else if (ena) begin
            eng_start_q <= 1'b0;
            count_q     <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q       <= rd_ptr_q + 1'b1;
                eng_features_q <= mem_q[rd_ptr_q];
                eng_start_q    <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q <= S_LAUNCH;
                    end
                end

                S_LAUNCH: begin
                    wdog_q  <= '0;
                    state_q <= S_WAIT;
                end

                S_WAIT: begin
                    // A done on the watchdog's final cycle still counts as a real result.
                    if (bus.eng_done) begin
                        votes_q <= votes_q + {3'b000, bus.eng_class};
                        cnt_q   <= cnt_q + 4'd1;
                        state_q <= S_ACCUM;
                    end else if (wdog_d == TIMEOUT_L) begin
                        wdog_q  <= wdog_d;
                        err_q   <= 1'b1;
                        cnt_q   <= cnt_q + 4'd1;
                        state_q <= S_ACCUM;
                    end else begin
                        wdog_q <= wdog_d;
                    end
                end

                S_ACCUM: begin
                    if (batch_full) begin
                        out_valid_q <= 1'b1;
                        out_votes_q <= votes_q;
                        out_class_q <= (votes_x2 > BATCH_X);
                        out_error_q <= err_q;
                        votes_q     <= '0;
                        cnt_q       <= '0;
                        err_q       <= 1'b0;
                        state_q     <= S_REPORT;
                    end else if (pop) begin
                        state_q <= S_LAUNCH;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end

                S_REPORT: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bnn_batch_sequencer.sv
// Directed bench for bnn_batch_sequencer: a timed engine responder plus a linear step sequence
// covering reset, voting, fill, watchdog abort, result backpressure and global enable.
module tb_bnn_batch_sequencer;
  localparam int DEPTH   = 4;
  localparam int BATCH   = 5;
  localparam int TIMEOUT = 15;

  logic clk = 1'b0;
  logic rst_n;
  logic ena;
  logic busy;

  bnn_batch_sequencer_if bus();

  bnn_batch_sequencer #(.DEPTH(DEPTH), .BATCH(BATCH), .TIMEOUT(TIMEOUT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          start_cnt = 0;
  int          cyc = 0;
  int          start_cyc[$];
  logic [15:0] feat_exp[$];
  int          cls_q[$];     // 0/1 = class to return, 2 = never answer
  int          resp_delay = 3;
  int          cd = 0;
  logic        resp_done = 1'b0, resp_class = 1'b0;
  logic        man_done = 1'b0, man_class = 1'b0;

  assign bus.eng_done  = resp_done | man_done;
  assign bus.eng_class = man_done ? man_class : resp_class;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Engine model: answers resp_delay cycles after each start, sampled away from the edge.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #2;
      resp_done = 1'b0;
      if (!rst_n) begin
        cd = 0;
      end else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) resp_done = 1'b1;
        end
        if (bus.eng_start === 1'b1) begin
          int c;
          start_cnt++;
          start_cyc.push_back(cyc);
          if (feat_exp.size() > 0) check("eng_features", 32'(bus.eng_features), 32'(feat_exp.pop_front()));
          else check("spurious_eng_start", 32'(bus.eng_start), 32'h0);
          if (cls_q.size() > 0) begin
            c = cls_q.pop_front();
            if (c != 2) begin
              resp_class = (c == 1);
              cd = resp_delay;
            end
          end
        end
      end
    end
  end

  task automatic push(input logic [15:0] f, input string tag);
    bus.in_valid    = 1'b1;
    bus.in_features = f;
    check(tag, 32'(bus.in_ready), 32'h1);
    if (bus.in_ready === 1'b1) feat_exp.push_back(f);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int k = 0;
    while (bus.in_ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(bus.in_ready), 32'h1);
  endtask

  task automatic expect_result(input string tag, input int base, input logic [3:0] v,
                               input logic c, input logic e);
    int k = 0;
    while (bus.out_valid !== 1'b1 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'h1);
    check({tag, "_out_votes"}, 32'(bus.out_votes), 32'(v));
    check({tag, "_out_class"}, 32'(bus.out_class), 32'(c));
    check({tag, "_out_error"}, 32'(bus.out_error), 32'(e));
    check({tag, "_starts"}, 32'(start_cnt - base), 32'(BATCH));
  endtask

  task automatic accept(input string tag);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_accepted"}, 32'(bus.out_valid), 32'h0);
  endtask

  task automatic wait_starts(input int n, input string tag);
    int k = 0;
    while (start_cnt < n && k < 200) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(start_cnt), 32'(n));
  endtask

  initial begin
    int  base;
    int  sc;
    logic stable;

    rst_n = 1'b0;
    ena   = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_features = '0;
    bus.out_ready   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_eng_start", 32'(bus.eng_start), 32'h0);
    check("rst_eng_features", 32'(bus.eng_features), 32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_votes", 32'(bus.out_votes), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_in_ready", 32'(bus.in_ready), 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // Batch 1: five back-to-back samples, classes 1,1,0,1,0 -> 3 votes, class 1
    base = start_cnt;
    resp_delay = 3;
    cls_q = '{1, 1, 0, 1, 0};
    push(16'h1111, "b1_push0");
    push(16'h2222, "b1_push1");
    push(16'h3333, "b1_push2");
    push(16'h4444, "b1_push3");
    push(16'h5555, "b1_push4");
    expect_result("b1", base, 4'd3, 1'b1, 1'b0);

    // Backpressure: result held 10 cycles, no launch, FIFO fills to 4
    cls_q = '{1, 2, 1, 0, 0};
    sc = start_cnt;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k < 4) push(16'hA000 + 16'(k), "bp_push");
      else @(negedge clk);
      if (!(bus.out_valid === 1'b1 && bus.out_votes === 4'd3 &&
            bus.out_class === 1'b1 && bus.out_error === 1'b0)) stable = 1'b0;
    end
    check("bp_out_stable", 32'(stable), 32'h1);
    check("bp_no_start", 32'(start_cnt), 32'(sc));
    check("bp_full_in_ready", 32'(bus.in_ready), 32'h0);
    check("bp_busy", 32'(busy), 32'h1);
    accept("b1");

    // Batch 2: sample 2 never answers -> watchdog abort, 2 votes, class 0, error
    base = sc;
    wait_ready("b2_space");
    push(16'hA004, "b2_push4");
    expect_result("b2", base, 4'd2, 1'b0, 1'b1);
    check("b2_timeout_gap", 32'(start_cyc[base+2] - start_cyc[base+1]), 32'(TIMEOUT + 2));
    accept("b2");
    check("b2_idle_busy", 32'(busy), 32'h0);

    // Batch 3: fill with sample 1 stalled, then ena low for 5 cycles with a stray done
    base = start_cnt;
    cls_q = '{2, 1, 1, 1, 0};
    push(16'hC000, "b3_push0");
    push(16'hC001, "b3_push1");
    push(16'hC002, "b3_push2");
    push(16'hC003, "b3_push3");
    push(16'hC004, "b3_push4");
    check("fill_in_ready", 32'(bus.in_ready), 32'h0);
    bus.in_valid    = 1'b1;
    bus.in_features = 16'hDEAD;
    repeat (2) begin
      @(negedge clk);
      check("fill_no_capture", 32'(bus.in_ready), 32'h0);
    end
    bus.in_valid = 1'b0;
    sc = start_cnt;
    ena = 1'b0;
    @(negedge clk);
    man_class = 1'b1;
    man_done  = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    check("ena_in_ready", 32'(bus.in_ready), 32'h0);
    check("ena_busy", 32'(busy), 32'h1);
    repeat (3) @(negedge clk);
    check("ena_no_start", 32'(start_cnt), 32'(sc));
    ena = 1'b1;
    expect_result("b3", base, 4'd3, 1'b1, 1'b1);
    check("b3_frozen_gap", 32'(start_cyc[base+1] - start_cyc[base]), 32'(TIMEOUT + 2 + 5));
    accept("b3");

    // Reset mid-batch while waiting with 3 votes banked
    base = start_cnt;
    cls_q = '{1, 1, 1, 2, 0};
    push(16'hE000, "b4_push0");
    push(16'hE001, "b4_push1");
    push(16'hE002, "b4_push2");
    push(16'hE003, "b4_push3");
    push(16'hE004, "b4_push4");
    wait_starts(base + 4, "b4_fourth_start");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_out_votes", 32'(bus.out_votes), 32'h0);
    check("mid_rst_out_class", 32'(bus.out_class), 32'h0);
    check("mid_rst_out_error", 32'(bus.out_error), 32'h0);
    check("mid_rst_eng_features", 32'(bus.eng_features), 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'h1);
    cls_q.delete();
    feat_exp.delete();
    rst_n = 1'b1;
    sc = start_cnt;
    man_class = 1'b1;
    man_done  = 1'b1;
    @(negedge clk);
    man_done = 1'b0;
    repeat (3) @(negedge clk);
    check("late_done_busy", 32'(busy), 32'h0);
    check("late_done_out_valid", 32'(bus.out_valid), 32'h0);
    check("late_done_no_start", 32'(start_cnt), 32'(sc));

    // Batch 5: fresh counters, classes 0,0,1,1,0 -> 2 votes, class 0
    base = start_cnt;
    resp_delay = 1;
    cls_q = '{0, 0, 1, 1, 0};
    push(16'h0F01, "b5_push0");
    push(16'h0F02, "b5_push1");
    push(16'h0F03, "b5_push2");
    push(16'h0F04, "b5_push3");
    push(16'h0F05, "b5_push4");
    expect_result("b5", base, 4'd2, 1'b0, 1'b0);
    accept("b5");
    @(negedge clk);
    check("end_busy", 32'(busy), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
